// File: rtl/if_id_stage.sv
// ==== if_id_stage : IF/ID pipeline register with immediate-format pre-decode | rev 1.0 ====
`default_nettype none

module if_id_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr_f,
  input  logic [XLEN-1:0] pc_f,
  input  logic [XLEN-1:0] pc_plus4_f,
  input  logic            valid_f,
  input  logic            stall_d,
  input  logic            flush_d,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic [24:0]     imm_d,
  output logic [2:0]      imm_src_d,
  output logic [4:0]      rs1_d,
  output logic [4:0]      rs2_d,
  output logic [4:0]      rd_d,
  output logic [6:0]      opcode_d,
  output logic [2:0]      funct3_d,
  output logic            funct7b5_d,
  output logic            illegal_d
);

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_J = 3'b110;

  logic [31:0]     ifid_instr_q,    ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q,       ifid_pc_d;
  logic [XLEN-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic            ifid_valid_q,    ifid_valid_d;
  logic [2:0]      ifid_imm_src_q,  ifid_imm_src_d;
  logic            ifid_illegal_q,  ifid_illegal_d;

  logic [2:0]      pre_imm_src;
  logic            pre_illegal;

  // Pre-decode in the fetch cycle so the format code lines up with instr_d.
  always_comb begin
    pre_imm_src = IMM_I;
    pre_illegal = 1'b0;
    unique case (instr_f[6:0])
      7'b0000011, 7'b0010011,
      7'b1100111, 7'b1110011: pre_imm_src = IMM_I;
      7'b0100011:             pre_imm_src = IMM_S;
      7'b0110111, 7'b0010111: pre_imm_src = IMM_U;
      7'b1100011:             pre_imm_src = IMM_B;
      7'b1101111:             pre_imm_src = IMM_J;
      7'b0110011:             pre_imm_src = IMM_I;
      default:                pre_illegal = valid_f;
    endcase
  end

  always_comb begin
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_imm_src_d  = ifid_imm_src_q;
    ifid_illegal_d  = ifid_illegal_q;
    if (flush_d) begin
      ifid_instr_d    = NOP_INSTR;
      ifid_pc_d       = '0;
      ifid_pc_plus4_d = '0;
      ifid_valid_d    = 1'b0;
      ifid_imm_src_d  = IMM_I;
      ifid_illegal_d  = 1'b0;
    end else if (!stall_d) begin
      ifid_instr_d    = instr_f;
      ifid_pc_d       = pc_f;
      ifid_pc_plus4_d = pc_plus4_f;
      ifid_valid_d    = valid_f;
      ifid_imm_src_d  = pre_imm_src;
      ifid_illegal_d  = pre_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_q       <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_valid_q    <= 1'b0;
      ifid_imm_src_q  <= IMM_I;
      ifid_illegal_q  <= 1'b0;
    end else begin
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_imm_src_q  <= ifid_imm_src_d;
      ifid_illegal_q  <= ifid_illegal_d;
    end
  end

  assign instr_d    = ifid_instr_q;
  assign pc_d       = ifid_pc_q;
  assign pc_plus4_d = ifid_pc_plus4_q;
  assign valid_d    = ifid_valid_q;
  assign imm_src_d  = ifid_imm_src_q;
  assign illegal_d  = ifid_illegal_q;

  assign imm_d      = ifid_instr_q[31:7];
  assign rs1_d      = ifid_instr_q[19:15];
  assign rs2_d      = ifid_instr_q[24:20];
  assign rd_d       = ifid_instr_q[11:7];
  assign opcode_d   = ifid_instr_q[6:0];
  assign funct3_d   = ifid_instr_q[14:12];
  assign funct7b5_d = ifid_instr_q[30];

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ==== tb_if_id_stage : randomized bench for if_id_stage against a table-driven model | rev 1.0 ====
`default_nettype none

module tb_if_id_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     instr_f;
  logic [XLEN-1:0] pc_f, pc_plus4_f;
  logic            valid_f, stall_d, flush_d;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d, pc_plus4_d;
  logic            valid_d, funct7b5_d, illegal_d;
  logic [24:0]     imm_d;
  logic [2:0]      imm_src_d, funct3_d;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic [6:0]      opcode_d;

  if_id_stage #(.XLEN(XLEN), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .instr_f(instr_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
    .valid_f(valid_f), .stall_d(stall_d), .flush_d(flush_d), .instr_d(instr_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .imm_d(imm_d),
    .imm_src_d(imm_src_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .opcode_d(opcode_d), .funct3_d(funct3_d), .funct7b5_d(funct7b5_d),
    .illegal_d(illegal_d)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Opcode -> immediate-format code; an opcode absent from the table is illegal.
  int          src_of [bit [6:0]];
  bit [6:0]    legal_ops [10];

  logic [31:0]     m_instr;
  logic [XLEN-1:0] m_pc, m_pc4;
  logic            m_valid, m_ill;
  logic [2:0]      m_src;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_instr = 32'h13; m_pc = '0; m_pc4 = '0; m_valid = 1'b0; m_src = 3'd0; m_ill = 1'b0;
  endtask

  task automatic model_edge();
    bit [6:0] op;
    if (flush_d) model_reset();
    else if (!stall_d) begin
      op      = instr_f[6:0];
      m_instr = instr_f;
      m_pc    = pc_f;
      m_pc4   = pc_plus4_f;
      m_valid = valid_f;
      if (src_of.exists(op)) begin
        m_src = 3'(src_of[op]);
        m_ill = 1'b0;
      end else begin
        m_src = 3'd0;
        m_ill = valid_f;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".instr"},   instr_d,    m_instr);
    check({tag, ".pc"},      pc_d,       m_pc);
    check({tag, ".pc4"},     pc_plus4_d, m_pc4);
    check({tag, ".valid"},   valid_d,    m_valid);
    check({tag, ".imm_src"}, imm_src_d,  m_src);
    check({tag, ".illegal"}, illegal_d,  m_ill);
    check({tag, ".imm"},     imm_d,      m_instr >> 7);
    check({tag, ".rs1"},     rs1_d,      (m_instr >> 15) & 32'h1F);
    check({tag, ".rs2"},     rs2_d,      (m_instr >> 20) & 32'h1F);
    check({tag, ".rd"},      rd_d,       (m_instr >> 7) & 32'h1F);
    check({tag, ".opcode"},  opcode_d,   m_instr & 32'h7F);
    check({tag, ".funct3"},  funct3_d,   (m_instr >> 12) & 32'h7);
    check({tag, ".f7b5"},    funct7b5_d, (m_instr >> 30) & 32'h1);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [XLEN-1:0] pc, input logic v);
    instr_f = ins; pc_f = pc; pc_plus4_f = pc + 4; valid_f = v;
  endtask

  logic [31:0] sweep_ins [4];
  logic [2:0]  sweep_src [4];

  initial begin
    src_of[7'b0000011] = 0; src_of[7'b0010011] = 0; src_of[7'b1100111] = 0;
    src_of[7'b1110011] = 0; src_of[7'b0100011] = 1; src_of[7'b0110111] = 2;
    src_of[7'b0010111] = 2; src_of[7'b1100011] = 5; src_of[7'b1101111] = 6;
    src_of[7'b0110011] = 0;
    legal_ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011,
                  7'b0110111, 7'b0010111, 7'b1100011, 7'b1101111, 7'b0110011};
    sweep_ins = '{32'h00112623, 32'h123450B7, 32'hFE208EE3, 32'h008000EF};
    sweep_src = '{3'b001, 3'b010, 3'b101, 3'b110};

    rst_n = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    drive(32'h0, '0, 1'b0);
    #12;
    model_reset();
    check_model("reset");
    check("reset.opcode_lit", opcode_d, 7'b0010011);

    // Async reset mid-cycle, then reload
    @(negedge clk) rst_n = 1'b1;
    drive(32'h002081B3, 32'h40, 1'b1);
    tick();
    check_model("pre_rst_load");
    drive(32'hFFF00093, 32'h44, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst.instr", instr_d, 32'h13);
    check_model("async_rst");
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst_rel.imm_src", imm_src_d, 3'b000);
    check("rst_rel.imm", imm_d, 25'h1FFE001);
    check_model("rst_rel");

    // Immediate-format sweep
    for (int i = 0; i < 4; i++) begin
      drive(sweep_ins[i], 32'h200 + 32'(4 * i), 1'b1);
      tick();
      check($sformatf("sweep%0d.imm_src", i), imm_src_d, sweep_src[i]);
      check($sformatf("sweep%0d.pc", i), pc_d, 32'h200 + 32'(4 * i));
      check_model($sformatf("sweep%0d", i));
    end

    // Stall holds for three cycles
    drive(32'h00000013, 32'h100, 1'b1);
    tick();
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h00000013, 32'h104 + 32'(4 * i), 1'b1);
      tick();
      check($sformatf("stall%0d.pc", i), pc_d, 32'h100);
      check_model($sformatf("stall%0d", i));
    end
    stall_d = 1'b0;
    tick();
    check("stall_rel.pc", pc_d, 32'h10C);

    // Flush beats stall
    drive(32'h00112623, 32'h300, 1'b1);
    tick();
    check("pre_flush.valid", valid_d, 1'b1);
    stall_d = 1'b1; flush_d = 1'b1;
    tick();
    check("flush.instr", instr_d, 32'h13);
    check("flush.valid", valid_d, 1'b0);
    check("flush.pc", pc_d, 32'h0);
    check_model("flush");
    stall_d = 1'b0; flush_d = 1'b0;

    // Unknown opcode, valid then invalid
    drive(32'h0000007F, 32'h400, 1'b1);
    tick();
    check("illegal_v.illegal", illegal_d, 1'b1);
    check("illegal_v.imm_src", imm_src_d, 3'b000);
    drive(32'h0000007F, 32'h404, 1'b0);
    tick();
    check("illegal_nv.illegal", illegal_d, 1'b0);
    check("illegal_nv.valid", valid_d, 1'b0);
    check_model("illegal_nv");

    // R-type
    drive(32'h002081B3, 32'h500, 1'b1);
    tick();
    check("rtype.illegal", illegal_d, 1'b0);
    check("rtype.imm_src", imm_src_d, 3'b000);
    check("rtype.rd", rd_d, 5'd3);
    check("rtype.rs1", rs1_d, 5'd1);
    check("rtype.rs2", rs2_d, 5'd2);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 9) < 7) ins[6:0] = legal_ops[$urandom_range(0, 9)];
      drive(ins, $urandom, 1'($urandom_range(0, 3) != 0));
      stall_d = ($urandom_range(0, 3) == 0);
      flush_d = ($urandom_range(0, 9) == 0);
      tick();
      check_model($sformatf("rnd%0d", n));
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model($sformatf("rnd_rst%0d", n));
        @(negedge clk) rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_id_stage.md
# if_id_stage

Fetch-to-decode pipeline register of the five-stage RISC-V core. Captures the fetched instruction, PC and PC+4 each cycle, pre-decodes the opcode into the 3-bit immediate-source code, and presents fields already sliced for the decode stage. That includes `imm_d[24:0]` (instruction bits 31:7), which feeds the immediate extender together with `imm_src_d`. Supports hazard-unit stall and branch/jump flush.

## Interface
Parameters:
- `XLEN`, 32, data/address width of the PC fields.
- `NOP_INSTR`, 32'h0000_0013, encoding inserted on reset/flush (`addi x0,x0,0`).

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_f` in 32: instruction from instruction memory.
- `pc_f` in XLEN: PC of `instr_f`.
- `pc_plus4_f` in XLEN: `pc_f + 4`.
- `valid_f` in 1: fetch slot holds a real instruction.
- `stall_d` in 1: hold all registers (from the hazard unit).
- `flush_d` in 1: replace contents with a bubble (taken branch/jump).
- `instr_d` out 32: registered instruction.
- `pc_d` out XLEN: registered PC.
- `pc_plus4_d` out XLEN: registered PC+4.
- `valid_d` out 1: decode slot is real.
- `imm_d` out 25: `instr_d[31:7]`.
- `imm_src_d` out 3: registered immediate-format code.
- `rs1_d`, `rs2_d`, `rd_d` out 5 each: `instr_d[19:15]`, `[24:20]`, `[11:7]`.
- `opcode_d` out 7, `funct3_d` out 3, `funct7b5_d` out 1: slices of `instr_d`.
- `illegal_d` out 1: registered unknown-opcode flag.

## Operation
- One register bank holds `instr`, `pc`, `pc_plus4`, `valid`, `imm_src` and `illegal`. Every other output is a pure slice of `instr_d`.
- `imm_src` is pre-decoded from `instr_f[6:0]` in the fetch cycle and registered, so it is aligned with `instr_d`:
  - I (000): 0000011 load, 0010011 op-imm, 1100111 jalr, 1110011 system.
  - S (001): 0100011.
  - U (010): 0110111 lui, 0010111 auipc.
  - B (101): 1100011.
  - J (110): 1101111.
  - R-type 0110011: 000, not illegal.
  - Any other opcode: 000, and `illegal` is set to `valid_f`.
- Update priority at each rising edge:
  1. `flush_d=1`: `instr<=NOP_INSTR`, `pc<=0`, `pc_plus4<=0`, `valid<=0`, `imm_src<=000`, `illegal<=0`.
  2. Else `stall_d=1`: every register holds its value.
  3. Else: load from the `_f` inputs and the pre-decode.
- Flush wins over stall when both are asserted in the same cycle.
- If `valid_f=0` on a load, the fields are captured as presented, `valid_d=0` and `illegal_d=0`.
- Reset (`rst_n` low, asynchronous, any time, including mid-stall) forces the same values as flush immediately, without waiting for a clock edge. Release is synchronous to the next edge.
- The block performs no arithmetic; `pc_plus4` passes through unchanged, with no wrap handling.

## Timing
- Latency: 1 cycle from the `_f` inputs to all `_d` outputs.
- All outputs come directly from flops or wire slices, with no combinational path from inputs to outputs.
- `stall_d` and `flush_d` are sampled at the rising edge and take effect on that edge.
- A stall of N cycles keeps the `_d` outputs constant for N cycles. The fetch stage holds `instr_f` stable during a stall (upstream contract, not checked here).
- Reset values of all outputs: `instr_d=32'h13`, `pc_d=0`, `pc_plus4_d=0`, `valid_d=0`, `imm_src_d=000`, `illegal_d=0`. The slices follow from `instr_d=32'h13`: `opcode_d=0010011`, `rd_d=0`, `rs1_d=0`, `imm_d=25'h0`.

## Test plan
- Reset: assert `rst_n=0` mid-cycle with `instr_f=32'hFFF00093`. Outputs go to the reset values immediately; after release, one edge loads the instruction, giving `imm_src_d=000` and `imm_d=25'h1FFE001`.
- Format sweep: feed `sw` 32'h00112623, `lui` 32'h123450B7, `beq` 32'hFE208EE3 and `jal` 32'h008000EF on consecutive cycles. Expect `imm_src_d` = 001, 010, 101, 110 in that order, each one cycle later, with `pc_d` tracking.
- Stall: load `pc_f=32'h100`, then hold `stall_d=1` for 3 cycles while `pc_f` changes. `pc_d` stays `32'h100` for 3 cycles and updates on the first edge after `stall_d=0`.
- Flush over stall: with `valid_d=1`, assert `stall_d=1` and `flush_d=1` together. Next cycle `instr_d=32'h13`, `valid_d=0`, `pc_d=0`.
- Illegal opcode: `instr_f=32'h0000007F` with `valid_f=1` gives `illegal_d=1`, `imm_src_d=000`. The same instruction with `valid_f=0` gives `illegal_d=0`, `valid_d=0`.
- R-type: `add` 32'h002081B3 gives `illegal_d=0`, `imm_src_d=000`, `rd_d=3`, `rs1_d=1`, `rs2_d=2`.
